ali_dmod_ctrl: RTL and testbench
================================

# ali_dmod_ctrl

AXI4-Lite control-register slave for the ALI demodulator (`ali_dmod`). It gives the host a 4 KB, 32-bit register window. Three read/write configuration words are exposed to the datapath as outputs. The block has no streaming datapath in this revision; the stream-width parameters are reserved.

## Interface
Parameters:
- C_S_AXI_CONTROL_ADDR_WIDTH, 12, AXI-Lite address width (byte address).
- C_S_AXI_CONTROL_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
- C_OUT_TDATA_WIDTH, 64, reserved output-stream width; unused.
- C_IN_TDATA_WIDTH, 64, reserved input-stream width; unused.
- C_TUSER_WIDTH, 8, reserved TUSER width; unused.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - ap_clk  in  1  the single clock.
  - ap_rst_n  in  1  synchronous, active-high reset; the codebase name is kept, and 1 = reset.
- Write address channel:
  - s_axi_control_awvalid in 1, s_axi_control_awready out 1, s_axi_control_awaddr in ADDR.
- Write data channel:
  - s_axi_control_wvalid in 1, s_axi_control_wready out 1, s_axi_control_wdata in DATA, s_axi_control_wstrb in DATA/8.
- Write response channel:
  - s_axi_control_bvalid out 1, s_axi_control_bready in 1, s_axi_control_bresp out 2.
- Read address channel:
  - s_axi_control_arvalid in 1, s_axi_control_arready out 1, s_axi_control_araddr in ADDR.
- Read data channel:
  - s_axi_control_rvalid out 1, s_axi_control_rready in 1, s_axi_control_rdata out DATA, s_axi_control_rresp out 2.
- Register outputs:
  - reg_arg0  out  32  value of register 0x010.
  - reg_arg1  out  32  value of register 0x018.
  - reg_arg2  out  32  value of register 0x020.

## Operation
- Register map (byte addresses, decoded on addr[11:2]):
  - 0x010 ARG0, RW.
  - 0x018 ARG1, RW.
  - 0x020 ARG2, RW.
  - All other offsets read 0x0000_0000; writes to them are ignored.
- Every access returns OKAY: bresp = rresp = 2'b00.
- Byte strobes: wstrb[i] = 1 updates byte i. wstrb = 0 performs no update but still completes the write and produces a response.
- Write FSM `wstate` (2 bits):
  - WR_IDLE = 0: awready = 1. On awvalid, latch awaddr and go to WR_DATA.
  - WR_DATA = 1: wready = 1. On wvalid, perform the write and go to WR_RESP.
  - WR_RESP = 2: bvalid = 1. On bready, go to WR_IDLE.
  - WR_RST = 3: reset state. All readies are 0; the FSM moves to WR_IDLE on the first cycle after reset deasserts.
- AW and W are accepted sequentially, never together. wvalid presented while in WR_IDLE waits until the FSM reaches WR_DATA.
- Read FSM (RD_IDLE, RD_DATA, RD_RST):
  - RD_IDLE: arready = 1. On arvalid, latch the addressed register into rdata and go to RD_DATA.
  - RD_DATA: rvalid = 1. On rready, go to RD_IDLE.
  - RD_RST behaves like WR_RST.
- rdata holds its last value after the handshake until the next read is accepted.
- The read and write FSMs are independent. A simultaneous read and write to the same register returns the pre-write value.

## Timing
- Reset values:
  - All registers and rdata = 0.
  - awready, wready, bvalid, arready and rvalid = 0.
  - wstate = WR_RST.
- First possible AW or AR acceptance is the 2nd cycle after reset deasserts.
- All outputs are registered.
- Write sequence:
  - AW handshake at edge N.
  - wready is high from N+1.
  - Register and reg_argX update at the W-handshake edge M.
  - bvalid is high from M+1 and stays high until the bready edge.
- Read sequence: AR handshake at edge N; rvalid and rdata are valid from N+1 and held until rready.
- A valid held while its ready is low must be tolerated indefinitely.
- Reset asserted mid-transaction aborts it: the FSMs return to RST and registers clear.

## Structure
- Shared package `ali_dmod_pkg`:
  - Register offsets ADDR_ARG0 = 12'h010, ADDR_ARG1 = 12'h018, ADDR_ARG2 = 12'h020.
  - Write-state encodings WR_IDLE/DATA/RESP/RST = 0/1/2/3.
  - Read-state encodings.
  - RESP_OKAY = 2'b00.
- One sub-module `ali_dmod_control_s_axi`, instantiated as `inst_control_s_axi`, holds the FSMs and registers. The top wraps it and exposes the `wstate` signal hierarchically for debug.

## Test plan
- Reset held for 200 cycles, then released → all readies 0 during reset, wstate = WR_RST, then WR_IDLE; reg_arg0–2 = 0.
- Write 0x010 = 0x1111_1111, 0x018 = 0x2222_2222, 0x020 = 0x3333_3333 (AW, then W, then B, sequential) → each gets bresp = 00 and reg_argX matches.
- Read 0x010, 0x018, 0x020 → rdata = 0x1111_1111 / 0x2222_2222 / 0x3333_3333 with rresp = 00; rdata still held after rready drops.
- Write 0x010 = 0xAABB_CCDD with wstrb = 4'b0101 over 0x1111_1111 → reads back 0x11BB_11DD.
- Read unmapped 0x004, and write 0x7FC → read returns 0, OKAY response, no register changes.
- Delay bready and rready by 5 cycles, and assert reset during WR_DATA → bvalid/rvalid hold until accepted; reset returns the FSM to WR_RST and clears the registers.

Source files
------------

// File: rtl/ali_dmod_pkg.sv
// Shared constants and helpers for the ALI demodulator control slave:
// register offsets, FSM encodings, address decode and byte-strobe merge.
package ali_dmod_pkg;

    localparam int          REG_ADDR_W = 12;
    localparam int          REG_DATA_W = 32;
    localparam int          REG_STRB_W = REG_DATA_W / 8;

    localparam logic [11:0] ADDR_ARG0  = 12'h010;
    localparam logic [11:0] ADDR_ARG1  = 12'h018;
    localparam logic [11:0] ADDR_ARG2  = 12'h020;

    localparam logic [1:0]  WR_IDLE    = 2'd0;
    localparam logic [1:0]  WR_DATA    = 2'd1;
    localparam logic [1:0]  WR_RESP    = 2'd2;
    localparam logic [1:0]  WR_RST     = 2'd3;

    localparam logic [1:0]  RD_IDLE    = 2'd0;
    localparam logic [1:0]  RD_DATA    = 2'd1;
    localparam logic [1:0]  RD_RST     = 2'd3;

    localparam logic [1:0]  RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        SEL_ARG0 = 2'd0,
        SEL_ARG1 = 2'd1,
        SEL_ARG2 = 2'd2,
        SEL_NONE = 2'd3
    } reg_sel_e;

    // Map a word address (byte address bits [11:2]) onto a register select.
    function automatic reg_sel_e decode_word(input logic [9:0] word);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (word == ADDR_ARG0[11:2]) begin
            sel = SEL_ARG0;
        end else if (word == ADDR_ARG1[11:2]) begin
            sel = SEL_ARG1;
        end else if (word == ADDR_ARG2[11:2]) begin
            sel = SEL_ARG2;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [REG_DATA_W-1:0] merge_bytes(
        input logic [REG_DATA_W-1:0] old_v,
        input logic [REG_DATA_W-1:0] new_v,
        input logic [REG_STRB_W-1:0] strb
    );
        logic [REG_DATA_W-1:0] merged;
        merged = old_v;
        for (int i = 0; i < REG_STRB_W; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ali_dmod_control_s_axi.sv
// AXI4-Lite register slave: independent write (AW -> W -> B) and read
// (AR -> R) FSMs plus the three ARG configuration registers.
module ali_dmod_control_s_axi
    import ali_dmod_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [REG_ADDR_W-1:0] awaddr,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [REG_DATA_W-1:0] wdata,
    input  logic [REG_STRB_W-1:0] wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [REG_ADDR_W-1:0] araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [REG_DATA_W-1:0] rdata,
    output logic [1:0]            rresp,
    output logic [REG_DATA_W-1:0] arg0,
    output logic [REG_DATA_W-1:0] arg1,
    output logic [REG_DATA_W-1:0] arg2,
    output logic [1:0]            wstate
);

    logic [1:0]            wstate_q, wstate_d;
    logic [9:0]            waddr_q, waddr_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [REG_DATA_W-1:0] arg0_q, arg0_d;
    logic [REG_DATA_W-1:0] arg1_q, arg1_d;
    logic [REG_DATA_W-1:0] arg2_q, arg2_d;
    logic [1:0]            rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [REG_DATA_W-1:0] rdata_q, rdata_d;

    // Byte-lane bits of the address never take part in decode.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{awaddr[1:0], araddr[1:0]};

    // Write FSM next state, register update and registered handshake flags.
    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        arg0_d   = arg0_q;
        arg1_d   = arg1_q;
        arg2_d   = arg2_q;
        case (wstate_q)
            WR_RST: begin
                wstate_d = WR_IDLE;
            end
            WR_IDLE: begin
                if (awvalid) begin
                    wstate_d = WR_DATA;
                    waddr_d  = awaddr[11:2];
                end else begin
                    wstate_d = WR_IDLE;
                end
            end
            WR_DATA: begin
                if (wvalid) begin
                    wstate_d = WR_RESP;
                    case (decode_word(waddr_q))
                        SEL_ARG0: arg0_d = merge_bytes(arg0_q, wdata, wstrb);
                        SEL_ARG1: arg1_d = merge_bytes(arg1_q, wdata, wstrb);
                        SEL_ARG2: arg2_d = merge_bytes(arg2_q, wdata, wstrb);
                        default:  arg0_d = arg0_q;
                    endcase
                end else begin
                    wstate_d = WR_DATA;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    wstate_d = WR_IDLE;
                end else begin
                    wstate_d = WR_RESP;
                end
            end
            default: begin
                wstate_d = WR_RST;
            end
        endcase
        // Handshake flags follow the next state so they leave a flop.
        awready_d = (wstate_d == WR_IDLE);
        wready_d  = (wstate_d == WR_DATA);
        bvalid_d  = (wstate_d == WR_RESP);
    end

    // Read FSM next state and read-data capture at AR acceptance.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            RD_RST: begin
                rstate_d = RD_IDLE;
            end
            RD_IDLE: begin
                if (arvalid) begin
                    rstate_d = RD_DATA;
                    // Uses current register values, so a same-cycle write
                    // to the same register is seen as its old value.
                    case (decode_word(araddr[11:2]))
                        SEL_ARG0: rdata_d = arg0_q;
                        SEL_ARG1: rdata_d = arg1_q;
                        SEL_ARG2: rdata_d = arg2_q;
                        default:  rdata_d = 32'h0000_0000;
                    endcase
                end else begin
                    rstate_d = RD_IDLE;
                end
            end
            RD_DATA: begin
                if (rready) begin
                    rstate_d = RD_IDLE;
                end else begin
                    rstate_d = RD_DATA;
                end
            end
            default: begin
                rstate_d = RD_RST;
            end
        endcase
        arready_d = (rstate_d == RD_IDLE);
        rvalid_d  = (rstate_d == RD_DATA);
    end

    // State, handshake and register flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= WR_RST;
            waddr_q   <= 10'd0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arg0_q    <= 32'h0000_0000;
            arg1_q    <= 32'h0000_0000;
            arg2_q    <= 32'h0000_0000;
            rstate_q  <= RD_RST;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            wstate_q  <= wstate_d;
            waddr_q   <= waddr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            arg0_q    <= arg0_d;
            arg1_q    <= arg1_d;
            arg2_q    <= arg2_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = RESP_OKAY;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = RESP_OKAY;
    assign arg0    = arg0_q;
    assign arg1    = arg1_q;
    assign arg2    = arg2_q;
    assign wstate  = wstate_q;

endmodule

// File: rtl/ali_dmod_ctrl.sv
// ALI demodulator control block: wraps the AXI4-Lite register slave and
// exposes the write FSM state as the internal signal `wstate` for debug.
module ali_dmod_ctrl
    import ali_dmod_pkg::*;
#(
    parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 12,
    parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32,
    parameter int C_OUT_TDATA_WIDTH          = 64,
    parameter int C_IN_TDATA_WIDTH           = 64,
    parameter int C_TUSER_WIDTH              = 8
)
(
    input  logic                                    ap_clk,
    input  logic                                    ap_rst_n,
    input  logic                                    s_axi_control_awvalid,
    output logic                                    s_axi_control_awready,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
    input  logic                                    s_axi_control_wvalid,
    output logic                                    s_axi_control_wready,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_wdata,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
    output logic                                    s_axi_control_bvalid,
    input  logic                                    s_axi_control_bready,
    output logic [1:0]                              s_axi_control_bresp,
    input  logic                                    s_axi_control_arvalid,
    output logic                                    s_axi_control_arready,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_araddr,
    output logic                                    s_axi_control_rvalid,
    input  logic                                    s_axi_control_rready,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_rdata,
    output logic [1:0]                              s_axi_control_rresp,
    output logic [31:0]                             reg_arg0,
    output logic [31:0]                             reg_arg1,
    output logic [31:0]                             reg_arg2
);

    // Stream widths are reserved for a later datapath revision.
    localparam int RSVD_W = C_OUT_TDATA_WIDTH + C_IN_TDATA_WIDTH + C_TUSER_WIDTH;

    logic [1:0] wstate;
    logic       unused_dbg;
    assign unused_dbg = ^{wstate, RSVD_W[0]};

    // ap_rst_n keeps its legacy name but is active-high: 1 = reset.
    ali_dmod_control_s_axi inst_control_s_axi (
        .clk     (ap_clk),
        .rst     (ap_rst_n),
        .awvalid (s_axi_control_awvalid),
        .awready (s_axi_control_awready),
        .awaddr  (s_axi_control_awaddr),
        .wvalid  (s_axi_control_wvalid),
        .wready  (s_axi_control_wready),
        .wdata   (s_axi_control_wdata),
        .wstrb   (s_axi_control_wstrb),
        .bvalid  (s_axi_control_bvalid),
        .bready  (s_axi_control_bready),
        .bresp   (s_axi_control_bresp),
        .arvalid (s_axi_control_arvalid),
        .arready (s_axi_control_arready),
        .araddr  (s_axi_control_araddr),
        .rvalid  (s_axi_control_rvalid),
        .rready  (s_axi_control_rready),
        .rdata   (s_axi_control_rdata),
        .rresp   (s_axi_control_rresp),
        .arg0    (reg_arg0),
        .arg1    (reg_arg1),
        .arg2    (reg_arg2),
        .wstate  (wstate)
    );

endmodule

// File: tb/tb_ali_dmod_ctrl.sv
// Self-checking bench for ali_dmod_ctrl: reset checks, a directed vector
// table, multi-cycle corner sequences and randomized traffic scored
// against a byte-address-keyed register model.
module tb_ali_dmod_ctrl;

    localparam int TO = 50;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic [11:0] awaddr = 12'h0, araddr = 12'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, reg_arg0, reg_arg1, reg_arg2;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] model [int];

    always #5 ap_clk = ~ap_clk;

    ali_dmod_ctrl dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready),
        .s_axi_control_awaddr(awaddr),
        .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready),
        .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb),
        .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready),
        .s_axi_control_bresp(bresp),
        .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready),
        .s_axi_control_araddr(araddr),
        .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready),
        .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp),
        .reg_arg0(reg_arg0), .reg_arg1(reg_arg1), .reg_arg2(reg_arg2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: only byte addresses 0x10, 0x18, 0x20 hold storage.
    task automatic model_reset();
        model.delete();
        model[16] = 32'h0;
        model[24] = 32'h0;
        model[32] = 32'h0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int k;
        k = int'(a & 12'hFFC);
        if (model.exists(k)) return model[k];
        return 32'h0;
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        logic [31:0] v;
        k = int'(a & 12'hFFC);
        if (model.exists(k)) begin
            v = model[k];
            for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
            model[k] = v;
        end
    endtask

    task automatic check_args(input string tag);
        check({tag, "_arg0"}, reg_arg0, model_read(12'h010));
        check({tag, "_arg1"}, reg_arg1, model_read(12'h018));
        check({tag, "_arg2"}, reg_arg2, model_read(12'h020));
    endtask

    // Full write: AW, then W (or W presented together with AW), then B.
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int bdly, input bit together);
        int n;
        bit hold_ok;
        @(negedge ap_clk);
        awvalid = 1'b1; awaddr = a;
        if (together) begin wvalid = 1'b1; wdata = d; wstrb = s; end
        n = 0;
        while (!awready && n < TO) begin @(negedge ap_clk); n++; end
        check("aw_handshake", {31'd0, awready}, 32'd1);
        if (together) check("w_not_with_aw", {31'd0, wready}, 32'd0);
        @(negedge ap_clk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = d; wstrb = s;
        n = 0;
        while (!wready && n < TO) begin @(negedge ap_clk); n++; end
        check("w_handshake", {31'd0, wready}, 32'd1);
        @(negedge ap_clk);
        wvalid = 1'b0;
        model_write(a, d, s);
        check("bvalid_after_w", {31'd0, bvalid}, 32'd1);
        check("arg_after_w", (a[11:2] == 10'h4) ? reg_arg0 : (a[11:2] == 10'h6) ? reg_arg1 :
              (a[11:2] == 10'h8) ? reg_arg2 : 32'h0, model_read(a));
        hold_ok = 1'b1;
        for (int i = 0; i < bdly; i++) begin
            if (!bvalid) hold_ok = 1'b0;
            @(negedge ap_clk);
        end
        if (bdly > 0) check("bvalid_hold", {31'd0, hold_ok}, 32'd1);
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < TO) begin @(negedge ap_clk); n++; end
        check("bresp", {30'd0, bresp}, 32'd0);
        @(negedge ap_clk);
        bready = 1'b0;
        check("bvalid_clear", {31'd0, bvalid}, 32'd0);
    endtask

    // Full read with optional rready delay; checks data, response and hold.
    task automatic axi_read(input logic [11:0] a, input logic [31:0] exp, input int rdly);
        int n;
        bit hold_ok;
        logic [31:0] got;
        @(negedge ap_clk);
        arvalid = 1'b1; araddr = a;
        n = 0;
        while (!arready && n < TO) begin @(negedge ap_clk); n++; end
        check("ar_handshake", {31'd0, arready}, 32'd1);
        @(negedge ap_clk);
        arvalid = 1'b0;
        got = rdata;
        hold_ok = 1'b1;
        for (int i = 0; i < rdly; i++) begin
            if (!rvalid || rdata !== got) hold_ok = 1'b0;
            @(negedge ap_clk);
        end
        if (rdly > 0) check("rvalid_hold", {31'd0, hold_ok}, 32'd1);
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < TO) begin @(negedge ap_clk); n++; end
        check("rdata", rdata, exp);
        check("rresp", {30'd0, rresp}, 32'd0);
        got = rdata;
        @(negedge ap_clk);
        rready = 1'b0;
        check("rvalid_clear", {31'd0, rvalid}, 32'd0);
        @(negedge ap_clk);
        check("rdata_held", rdata, got);
    endtask

    typedef struct {
        bit          is_wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic [31:0] exp0, exp1, exp2;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [11:0] a;
        logic [31:0] d, old_v, new_v;
        int n;

        vecs[0]  = '{1'b1, 12'h010, 32'h1111_1111, 4'hF, 32'h0,         32'h1111_1111, 32'h0,         32'h0};
        vecs[1]  = '{1'b1, 12'h018, 32'h2222_2222, 4'hF, 32'h0,         32'h1111_1111, 32'h2222_2222, 32'h0};
        vecs[2]  = '{1'b1, 12'h020, 32'h3333_3333, 4'hF, 32'h0,         32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        vecs[3]  = '{1'b0, 12'h010, 32'h0, 4'h0,         32'h1111_1111, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        vecs[4]  = '{1'b0, 12'h018, 32'h0, 4'h0,         32'h2222_2222, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        vecs[5]  = '{1'b0, 12'h020, 32'h0, 4'h0,         32'h3333_3333, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        vecs[6]  = '{1'b1, 12'h010, 32'hAABB_CCDD, 4'b0101, 32'h0,      32'h11BB_11DD, 32'h2222_2222, 32'h3333_3333};
        vecs[7]  = '{1'b0, 12'h010, 32'h0, 4'h0,         32'h11BB_11DD, 32'h11BB_11DD, 32'h2222_2222, 32'h3333_3333};
        vecs[8]  = '{1'b0, 12'h004, 32'h0, 4'h0,         32'h0,         32'h11BB_11DD, 32'h2222_2222, 32'h3333_3333};
        vecs[9]  = '{1'b1, 12'h7FC, 32'hDEAD_BEEF, 4'hF, 32'h0,         32'h11BB_11DD, 32'h2222_2222, 32'h3333_3333};
        vecs[10] = '{1'b0, 12'h7FC, 32'h0, 4'h0,         32'h0,         32'h11BB_11DD, 32'h2222_2222, 32'h3333_3333};
        vecs[11] = '{1'b1, 12'h018, 32'h5555_5555, 4'h0, 32'h0,         32'h11BB_11DD, 32'h2222_2222, 32'h3333_3333};
        vecs[12] = '{1'b0, 12'h018, 32'h0, 4'h0,         32'h2222_2222, 32'h11BB_11DD, 32'h2222_2222, 32'h3333_3333};
        vecs[13] = '{1'b0, 12'h014, 32'h0, 4'h0,         32'h0,         32'h11BB_11DD, 32'h2222_2222, 32'h3333_3333};
        vecs[14] = '{1'b1, 12'h022, 32'h0000_00EE, 4'b0001, 32'h0,      32'h11BB_11DD, 32'h2222_2222, 32'h3333_33EE};

        // ---- reset held 200 cycles ----
        model_reset();
        ap_rst_n = 1'b1;
        repeat (100) @(negedge ap_clk);
        check("rst_ready", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        check("rst_wstate", {30'd0, dut.wstate}, 32'd3);
        check("rst_rdata", rdata, 32'h0);
        check_args("rst");
        repeat (100) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        check("post_rst_wstate", {30'd0, dut.wstate}, 32'd0);
        check("post_rst_ready", {29'd0, awready, wready, arready}, 32'b101);

        // ---- directed table ----
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 1'b0);
            else               axi_read(vecs[i].addr, vecs[i].exp_rd, 0);
            check("tbl_arg0", reg_arg0, vecs[i].exp0);
            check("tbl_arg1", reg_arg1, vecs[i].exp1);
            check("tbl_arg2", reg_arg2, vecs[i].exp2);
        end

        // ---- delayed bready / rready, W presented together with AW ----
        axi_write(12'h018, 32'h0BAD_F00D, 4'hF, 5, 1'b0);
        axi_read(12'h018, 32'h0BAD_F00D, 5);
        axi_write(12'h010, 32'hCAFE_0001, 4'b1100, 2, 1'b1);
        axi_read(12'h010, model_read(12'h010), 0);

        // ---- simultaneous write and read of the same register ----
        @(negedge ap_clk);
        awvalid = 1'b1; awaddr = 12'h020;
        n = 0;
        while (!awready && n < TO) begin @(negedge ap_clk); n++; end
        @(negedge ap_clk);
        awvalid = 1'b0;
        old_v = model_read(12'h020);
        new_v = ~old_v;
        check("sim_ready", {30'd0, wready, arready}, 32'b11);
        wvalid = 1'b1; wdata = new_v; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 12'h020;
        @(negedge ap_clk);
        wvalid = 1'b0; arvalid = 1'b0;
        model_write(12'h020, new_v, 4'hF);
        check("sim_rvalid", {30'd0, rvalid, bvalid}, 32'b11);
        check("sim_rdata_old", rdata, old_v);
        check("sim_arg2_new", reg_arg2, new_v);
        bready = 1'b1; rready = 1'b1;
        @(negedge ap_clk);
        bready = 1'b0; rready = 1'b0;
        check("sim_clear", {30'd0, rvalid, bvalid}, 32'd0);

        // ---- reset asserted during WR_DATA ----
        @(negedge ap_clk);
        awvalid = 1'b1; awaddr = 12'h018;
        n = 0;
        while (!awready && n < TO) begin @(negedge ap_clk); n++; end
        @(negedge ap_clk);
        awvalid = 1'b0;
        check("mid_wstate_data", {30'd0, dut.wstate}, 32'd1);
        ap_rst_n = 1'b1;
        wvalid = 1'b1; wdata = 32'h7777_7777; wstrb = 4'hF;
        @(negedge ap_clk);
        wvalid = 1'b0;
        model_reset();
        check("mid_rst_wstate", {30'd0, dut.wstate}, 32'd3);
        check("mid_rst_ready", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        check_args("mid_rst");
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        check("mid_rel_wstate", {30'd0, dut.wstate}, 32'd0);
        axi_read(12'h018, 32'h0, 0);

        // ---- randomized traffic against the model ----
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 4))
                0: a = 12'h010 | 12'($urandom_range(0, 3));
                1: a = 12'h018 | 12'($urandom_range(0, 3));
                2: a = 12'h020 | 12'($urandom_range(0, 3));
                default: a = 12'($urandom);
            endcase
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, d, 4'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                check_args("rnd");
            end else begin
                axi_read(a, model_read(a), $urandom_range(0, 3));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
